// File: rtl/sonic_tx_arb_pkg.sv
// Shared types and constants for the PCIe TX-port arbiter.
package sonic_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_BUSY
    } arb_state_t;

    localparam int unsigned MAX_CLIENTS     = 8;
    localparam int unsigned TX_W            = 128;
    localparam logic [15:0] TIMEOUT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sonic_rr_picker.sv
// Combinational round-robin picker: first set request after `last`, searching upward and wrapping.
module sonic_rr_picker #(
    parameter  int unsigned N = 3,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] winner
);

    logic [W:0]   w_start;
    logic [N-1:0] w_rot;
    logic [W:0]   w_off;
    logic [W:0]   w_sum;

    always_comb begin
        w_start = {1'b0, last} + (W+1)'(1);
        // Doubling the vector turns the wrap-around rotate into a plain shift.
        w_rot   = N'({req, req} >> w_start);
        valid   = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                valid = 1'b1;
                w_off = (W+1)'(k);
            end
        end
        w_sum = w_start + w_off;
        if (w_sum >= (W+1)'(N)) begin
            w_sum = w_sum - (W+1)'(N);
        end
        winner = w_sum[W-1:0];
    end

endmodule

// File: rtl/sonic_tx_sel_arbiter.sv
// Round-robin owner arbitration and TX-signal steering between the PCIe core and its TX clients.
module sonic_tx_sel_arbiter
    import sonic_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS   = 3,
    parameter int unsigned GRANT_TIMEOUT = 64
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic [NUM_CLIENTS-1:0]      cl_ready,
    input  logic [NUM_CLIENTS-1:0]      cl_busy,
    output logic [NUM_CLIENTS-1:0]      cl_sel,
    output logic [NUM_CLIENTS-1:0]      cl_ready_others,
    input  logic [NUM_CLIENTS-1:0]      cl_req,
    input  logic [NUM_CLIENTS-1:0]      cl_dfr,
    input  logic [NUM_CLIENTS-1:0]      cl_dv,
    input  logic [NUM_CLIENTS-1:0]      cl_err,
    input  logic [NUM_CLIENTS*TX_W-1:0] cl_desc,
    input  logic [NUM_CLIENTS*TX_W-1:0] cl_data,
    output logic [NUM_CLIENTS-1:0]      cl_ack,
    output logic [NUM_CLIENTS-1:0]      cl_ws,
    output logic                        tx_req,
    output logic                        tx_dfr,
    output logic                        tx_dv,
    output logic                        tx_err,
    output logic [TX_W-1:0]             tx_desc,
    output logic [TX_W-1:0]             tx_data,
    input  logic                        tx_ack,
    input  logic                        tx_ws,
    output logic [15:0]                 timeout_cnt
);

    localparam int unsigned G_W    = $clog2(NUM_CLIENTS);
    localparam int unsigned WAIT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    localparam bit          TO_EN  = (GRANT_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = TO_EN ? WAIT_W'(GRANT_TIMEOUT - 1) : '0;

    arb_state_t             r_state;
    logic [G_W-1:0]         r_g;
    logic [G_W-1:0]         r_last;
    logic [NUM_CLIENTS-1:0] r_sel;
    logic [WAIT_W-1:0]      r_wait;
    logic [15:0]            r_timeout_cnt;

    logic                   w_pick_valid;
    logic [G_W-1:0]         w_pick;
    logic                   w_active;
    logic [NUM_CLIENTS-1:0] w_own;

    sonic_rr_picker #(
        .N (NUM_CLIENTS)
    ) u_picker (
        .req    (cl_ready),
        .last   (r_last),
        .valid  (w_pick_valid),
        .winner (w_pick)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= ARB_IDLE;
            r_g           <= '0;
            r_last        <= G_W'(NUM_CLIENTS - 1);
            r_sel         <= '0;
            r_wait        <= '0;
            r_timeout_cnt <= '0;
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state <= ARB_GRANT;
                        r_g     <= w_pick;
                        r_last  <= w_pick;
                        r_sel   <= NUM_CLIENTS'(1) << w_pick;
                        r_wait  <= '0;
                    end
                end
                ARB_GRANT: begin
                    // Busy wins over a simultaneous ready drop.
                    if (cl_busy[r_g]) begin
                        r_state <= ARB_BUSY;
                    end else if (!cl_ready[r_g]) begin
                        r_state <= ARB_IDLE;
                        r_sel   <= '0;
                    end else if (TO_EN && (r_wait == WAIT_LAST)) begin
                        r_state <= ARB_IDLE;
                        r_sel   <= '0;
                        if (r_timeout_cnt != TIMEOUT_CNT_MAX) begin
                            r_timeout_cnt <= r_timeout_cnt + 16'd1;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ARB_BUSY: begin
                    if (!cl_busy[r_g]) begin
                        r_state <= ARB_IDLE;
                        r_sel   <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_sel   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_active = (r_state != ARB_IDLE);
        tx_req   = w_active & cl_req[r_g];
        tx_dfr   = w_active & cl_dfr[r_g];
        tx_dv    = w_active & cl_dv[r_g];
        tx_err   = w_active & cl_err[r_g];
        tx_desc  = w_active ? cl_desc[r_g*TX_W +: TX_W] : '0;
        tx_data  = w_active ? cl_data[r_g*TX_W +: TX_W] : '0;
    end

    // Non-owners see a permanent wait-state so they never believe the core accepted them.
    always_comb begin
        w_own           = '0;
        cl_ack          = '0;
        cl_ws           = '1;
        cl_ready_others = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_own[i]           = w_active && (r_g == G_W'(i));
            cl_ack[i]          = w_own[i] & tx_ack;
            cl_ws[i]           = w_own[i] ? tx_ws : 1'b1;
            cl_ready_others[i] = |(cl_ready & ~(NUM_CLIENTS'(1) << i));
        end
    end

    assign cl_sel      = r_sel;
    assign timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_sonic_tx_sel_arbiter.sv
// Directed plus randomized bench for sonic_tx_sel_arbiter, checked against a behavioural owner model.
module tb_sonic_tx_sel_arbiter;

    localparam int N   = 3;
    localparam int TO  = 8;
    localparam int TXW = 128;

    logic             clk_in = 1'b0;
    logic             reset;
    logic [N-1:0]     cl_ready, cl_busy, cl_sel, cl_ready_others;
    logic [N-1:0]     cl_req, cl_dfr, cl_dv, cl_err, cl_ack, cl_ws;
    logic [N*TXW-1:0] cl_desc, cl_data;
    logic             tx_req, tx_dfr, tx_dv, tx_err, tx_ack, tx_ws;
    logic [TXW-1:0]   tx_desc, tx_data;
    logic [15:0]      timeout_cnt;

    always #5 clk_in = ~clk_in;

    sonic_tx_sel_arbiter #(
        .NUM_CLIENTS   (N),
        .GRANT_TIMEOUT (TO)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .cl_ready        (cl_ready),
        .cl_busy         (cl_busy),
        .cl_sel          (cl_sel),
        .cl_ready_others (cl_ready_others),
        .cl_req          (cl_req),
        .cl_dfr          (cl_dfr),
        .cl_dv           (cl_dv),
        .cl_err          (cl_err),
        .cl_desc         (cl_desc),
        .cl_data         (cl_data),
        .cl_ack          (cl_ack),
        .cl_ws           (cl_ws),
        .tx_req          (tx_req),
        .tx_dfr          (tx_dfr),
        .tx_dv           (tx_dv),
        .tx_err          (tx_err),
        .tx_desc         (tx_desc),
        .tx_data         (tx_data),
        .tx_ack          (tx_ack),
        .tx_ws           (tx_ws),
        .timeout_cnt     (timeout_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Model: who owns the port (-1 = nobody), whether it has gone busy, rotation pointer, counters.
    int m_owner;
    bit m_owned;
    int m_last;
    int m_wait;
    int m_to;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic rs, input logic [N-1:0] r, input logic [N-1:0] b);
        if (rs) begin
            m_owner = -1;
            m_owned = 1'b0;
            m_last  = N - 1;
            m_wait  = 0;
            m_to    = 0;
        end else if (m_owner < 0) begin
            for (int s = 1; s <= N; s++) begin
                if (m_owner < 0 && r[(m_last + s) % N]) begin
                    m_owner = (m_last + s) % N;
                    m_last  = m_owner;
                    m_wait  = 0;
                    m_owned = 1'b0;
                end
            end
        end else if (!m_owned) begin
            if (b[m_owner]) m_owned = 1'b1;
            else if (!r[m_owner]) m_owner = -1;
            else if (m_wait == TO - 1) begin
                m_owner = -1;
                if (m_to < 65535) m_to++;
            end else m_wait++;
        end else if (!b[m_owner]) begin
            m_owner = -1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] r, b;
        logic         rs;
        r  = cl_ready;
        b  = cl_busy;
        rs = reset;
        @(posedge clk_in);
        model_update(rs, r, b);
        #1;
    endtask

    task automatic check_all(input string ph);
        logic [N-1:0]   e_sel, e_ack, e_ws, e_ro;
        logic [3:0]     e_ctl;
        logic [TXW-1:0] e_desc, e_data;
        e_sel  = '0;
        e_ctl  = '0;
        e_desc = '0;
        e_data = '0;
        if (m_owner >= 0) begin
            e_sel[m_owner] = 1'b1;
            e_ctl  = {cl_req[m_owner], cl_dfr[m_owner], cl_dv[m_owner], cl_err[m_owner]};
            e_desc = cl_desc[m_owner*TXW +: TXW];
            e_data = cl_data[m_owner*TXW +: TXW];
        end
        for (int i = 0; i < N; i++) begin
            e_ack[i] = (i == m_owner) ? tx_ack : 1'b0;
            e_ws[i]  = (i == m_owner) ? tx_ws : 1'b1;
            e_ro[i]  = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (j != i && cl_ready[j]) e_ro[i] = 1'b1;
            end
        end
        chk({ph, ".sel"}, 128'(cl_sel), 128'(e_sel));
        chk({ph, ".tocnt"}, 128'(timeout_cnt), 128'(m_to));
        chk({ph, ".ctl"}, 128'({tx_req, tx_dfr, tx_dv, tx_err}), 128'(e_ctl));
        chk({ph, ".desc"}, tx_desc, e_desc);
        chk({ph, ".data"}, tx_data, e_data);
        chk({ph, ".ack"}, 128'(cl_ack), 128'(e_ack));
        chk({ph, ".ws"}, 128'(cl_ws), 128'(e_ws));
        chk({ph, ".rdy_oth"}, 128'(cl_ready_others), 128'(e_ro));
    endtask

    task automatic fill_data();
        for (int w = 0; w < N * TXW / 32; w++) begin
            cl_desc[w*32 +: 32] = $urandom();
            cl_data[w*32 +: 32] = $urandom();
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        logic [TXW-1:0] d0, d1;
        logic [N-1:0]   prev_sel;
        int             grants[$];
        int             gaps[$];
        int             holds[$];
        int             rem[N];
        int             run;
        int             first_to;

        reset    = 1'b1;
        cl_ready = '0;
        cl_busy  = '0;
        cl_req   = '0;
        cl_dfr   = '0;
        cl_dv    = '0;
        cl_err   = '0;
        cl_desc  = '0;
        cl_data  = '0;
        tx_ack   = 1'b0;
        tx_ws    = 1'b0;
        m_owner  = -1;
        m_owned  = 1'b0;
        m_last   = N - 1;
        m_wait   = 0;
        m_to     = 0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst.sel", 128'(cl_sel), 128'(0));
        chk("rst.tocnt", 128'(timeout_cnt), 128'(0));
        chk("rst.ws", 128'(cl_ws), 128'(3'b111));
        check_all("rst");

        // Single client 1
        fill_data();
        d1       = cl_desc[TXW +: TXW];
        cl_req   = 3'b010;
        cl_ready = 3'b010;
        tick();
        check_all("s1");
        chk("s1.grant", 128'(cl_sel), 128'(3'b010));
        tick();
        check_all("s1");
        cl_busy = 3'b010;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_all("s1");
            chk("s1.desc_own", tx_desc, d1);
            chk("s1.ws_other", 128'({cl_ws[2], cl_ws[0]}), 128'(2'b11));
        end
        cl_ready = '0;
        cl_busy  = '0;
        tick();
        check_all("s1");
        chk("s1.release", 128'(cl_sel), 128'(0));

        // Fairness with everyone ready
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        cl_ready = '1;
        prev_sel = '0;
        run      = 0;
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            check_all("fair");
            for (int i = 0; i < N; i++) begin
                if (cl_sel[i] && !prev_sel[i]) begin
                    grants.push_back(i);
                    cl_busy[i] = 1'b1;
                    rem[i]     = 4;
                end else if (cl_busy[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) cl_busy[i] = 1'b0;
                end
            end
            if (cl_sel == '0) run++;
            else if (run > 0) begin
                gaps.push_back(run);
                run = 0;
            end
            prev_sel = cl_sel;
        end
        for (int k = 0; k < 6; k++) begin
            chk("fair.order", 128'((k < grants.size()) ? grants[k] : -1), 128'(k % N));
        end
        for (int k = 0; k < 5; k++) begin
            chk("fair.gap", 128'((k < gaps.size()) ? gaps[k] : -1), 128'(1));
        end

        // Grant timeout, then rotation continues past the timed-out client
        cl_busy  = '0;
        cl_ready = '0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        cl_ready = 3'b100;
        grants.delete();
        prev_sel = '0;
        run      = 0;
        first_to = -1;
        for (int c = 0; c < 60; c++) begin
            tick();
            check_all("to");
            if (cl_sel != '0 && prev_sel == '0) grants.push_back(onehot_idx(cl_sel));
            if (cl_sel != '0) run++;
            else if (prev_sel != '0) begin
                holds.push_back(run);
                run = 0;
                if (first_to < 0) first_to = int'(timeout_cnt);
            end
            if (grants.size() > 0) cl_ready = 3'b111;
            prev_sel = cl_sel;
        end
        chk("to.first_cnt", 128'(first_to), 128'(1));
        for (int k = 0; k < 3; k++) begin
            chk("to.hold", 128'((k < holds.size()) ? holds[k] : -1), 128'(TO));
        end
        for (int k = 0; k < 4; k++) begin
            chk("to.order", 128'((k < grants.size()) ? grants[k] : -1), 128'((k + 2) % N));
        end

        // Ready falls exactly as busy rises: must become busy, not release
        cl_ready = '0;
        tick();
        tick();
        check_all("sim");
        cl_ready = 3'b010;
        tick();
        check_all("sim");
        cl_ready = 3'b000;
        cl_busy  = 3'b010;
        tick();
        check_all("sim");
        tick();
        check_all("sim");
        chk("sim.held", 128'(cl_sel), 128'(3'b010));
        cl_busy = '0;
        tick();
        check_all("sim");

        // Reset while client 0 is mid-transaction
        cl_ready = 3'b001;
        cl_req   = 3'b001;
        for (int c = 0; c < 5 && cl_sel != 3'b001; c++) tick();
        chk("rb.grant", 128'(cl_sel), 128'(3'b001));
        cl_busy = 3'b001;
        tick();
        check_all("rb");
        chk("rb.req_on", 128'(tx_req), 128'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rb.sel", 128'(cl_sel), 128'(0));
        chk("rb.req_off", 128'(tx_req), 128'(0));
        chk("rb.tocnt", 128'(timeout_cnt), 128'(0));
        check_all("rb");
        cl_busy  = '0;
        cl_ready = 3'b111;
        tick();
        check_all("rb");
        chk("rb.next", 128'(cl_sel), 128'(3'b001));

        // Stray busy from a non-owner
        fill_data();
        d0      = cl_desc[0 +: TXW];
        cl_busy = 3'b011;
        cl_req  = 3'b010;
        tx_ack  = 1'b1;
        tx_ws   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_all("stray");
            chk("stray.desc", tx_desc, d0);
            chk("stray.ack1", 128'(cl_ack[1]), 128'(0));
            chk("stray.req", 128'(tx_req), 128'(0));
        end
        cl_busy  = '0;
        cl_ready = '0;
        tick();
        check_all("stray");

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            cl_ready = N'($urandom() | $urandom());
            cl_busy  = N'($urandom() & $urandom());
            cl_req   = N'($urandom());
            cl_dfr   = N'($urandom());
            cl_dv    = N'($urandom());
            cl_err   = N'($urandom());
            tx_ack   = 1'($urandom());
            tx_ws    = 1'($urandom());
            fill_data();
            tick();
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sonic_tx_sel_arbiter.md
# sonic_tx_sel_arbiter

Round-robin arbiter and multiplexer for the PCIe Avalon-ST TX descriptor/data interface. Sits between the PCIe hard-IP TX port and the TX-issuing clients: the chaining-DMA read and write engines and `sonic_irq_ctl`. It drives each client's `tx_sel`/`tx_ready_others` and watches its `tx_ready`/`tx_busy` handshake. It grants exclusive ownership of the TX port to one client per transaction and steers that client's TX signals to the core.

## Interface
- `NUM_CLIENTS`, default 3: number of requesters, 2..8; index 0 = irq_ctl.
- `GRANT_TIMEOUT`, default 64: cycles a granted client may hold `sel` without raising `busy`; 0 disables the timeout.

Ports:
- `clk_in` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `cl_ready` in N: client wants the TX port.
- `cl_busy` in N: client is mid-transaction.
- `cl_sel` out N: one-hot grant, registered.
- `cl_ready_others` out N: bit i = OR of `cl_ready` excluding i.
- `cl_req`, `cl_dfr`, `cl_dv`, `cl_err` in N each: per-client TX controls.
- `cl_desc`, `cl_data` in N*128: flattened; client i occupies bits [128i+127:128i].
- `cl_ack` out N: core ack, routed to the owner only.
- `cl_ws` out N: core wait-state, routed to the owner only.
- `tx_req`, `tx_dfr`, `tx_dv`, `tx_err` out 1 each: to the core.
- `tx_desc`, `tx_data` out 128 each: to the core.
- `tx_ack`, `tx_ws` in 1 each: from the core.
- `timeout_cnt` out 16: saturating count of revoked grants.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: `cl_sel[g]`=1, waiting for `cl_busy[g]`.
  - BUSY: client g owns the port.
- Transitions:
  - IDLE → GRANT: any `cl_ready` is high. The winner is the first ready index after `last_grant`, searching upward and wrapping. The winner is registered into `g` and `cl_sel`. `last_grant` ← winner.
  - GRANT → BUSY: `cl_busy[g]`.
  - GRANT → IDLE, release: `!cl_ready[g] && !cl_busy[g]`.
  - GRANT → IDLE, timeout: wait counter reaches `GRANT_TIMEOUT-1` without busy. `timeout_cnt` increments, saturating at 0xFFFF.
  - BUSY → IDLE: `!cl_busy[g]`.
  - When `busy` and `ready` deassert in the same cycle, `busy` takes precedence: GRANT goes to BUSY.
- `cl_sel` is all-zero in IDLE, one-hot otherwise. It deasserts on the edge that enters IDLE.
- Core-side mux, combinational from registered `g`:
  - In GRANT/BUSY: `tx_*` = client g's signals.
  - In IDLE: `tx_req`/`tx_dv`/`tx_dfr`/`tx_err`=0, `tx_desc`/`tx_data`=0.
- Return path:
  - `cl_ack[g]` = `tx_ack`, `cl_ws[g]` = `tx_ws`.
  - Non-owners see `cl_ack`=0 and `cl_ws`=1.
  - In IDLE, all `cl_ws`=1.
- `cl_ready_others` is combinational and is computed in every state.
- A client that raises `busy` without `sel` is ignored: no mux, no state change.
- Reset values: state IDLE, `cl_sel`=0, `g`=0, `last_grant`=N-1 (client 0 wins first), wait counter 0, `timeout_cnt`=0.
- Reset asserted mid-transaction: the next edge forces the reset values and `tx_req`/`tx_dv` drop. Recovery of the abandoned client is the client's own reset.

## Timing
- Grant latency: `cl_ready[i]` high at edge k with the arbiter in IDLE → `cl_sel[i]`=1 after edge k+1.
- Minimum back-to-back gap is 1 IDLE cycle between owners. For example, BUSY→IDLE at edge m allows a new grant at edge m+1.
- Round-robin fairness: with all clients continuously ready, each is granted once per N transactions.
- Mux and ack/ws steering add 0 cycles; there are no registers on the data path.
- The wait counter clears on entry to GRANT. A timeout fires on the `GRANT_TIMEOUT`-th cycle in GRANT.

## Structure
- `sonic_tx_arb_pkg`:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BUSY} arb_state_t`
  - `localparam MAX_CLIENTS = 8`
  - `localparam TX_W = 128`
- Sub-module `sonic_rr_picker`: combinational, parameter N. Inputs are `req[N]` and `last[$clog2(N)]`. Outputs are `valid` and `winner[$clog2(N)]`, found by a rotate, priority-encode, unrotate search.
- The top file holds the FSM, counters, mux and return-path steering.

## Test plan
- Single client: reset, raise `cl_ready[1]`, raise busy 2 cycles later, hold 10 cycles, drop both.
  - `cl_sel`=3'b010 one cycle after ready.
  - `tx_desc` equals client 1's desc while owned; `cl_ws[0]`=`cl_ws[2]`=1 throughout.
  - `cl_sel`=0 after busy falls.
- Fairness: all three ready continuously, each busy for 4 cycles per grant → grant order 0,1,2,0,1,2 with one IDLE cycle between owners.
- Timeout: `GRANT_TIMEOUT`=8, client 2 ready but never busy → `cl_sel[2]` held exactly 8 cycles, then `timeout_cnt`=1, then client 2 is re-granted only after other ready clients.
- Simultaneous edge case: in GRANT, `cl_ready[g]` falls on the same cycle `cl_busy[g]` rises → arbiter enters BUSY; no release.
- Reset mid-BUSY: assert `reset` for 1 cycle while client 0 drives `tx_req`=1 → after the edge, `cl_sel`=0, `tx_req`=0, `timeout_cnt`=0, and the next grant goes to client 0.
- Stray busy: `cl_busy[1]` high while client 0 owns the port → `tx_*` keep carrying client 0's signals and `cl_ack[1]` stays 0.
